// File: rtl/uart_frame_deframer.sv
// Framed-packet parser behind the UART receiver: SYNC, LEN, payload, CHK -> valid/ready byte stream.
// Define UART_DEFRAMER_CRC8_EN to use CRC-8 (poly 0x07) instead of the XOR integrity byte.
`timescale 1ns/1ps

module uart_frame_deframer #(
    parameter logic [7:0] SYNC_BYTE = 8'hAA,
    parameter int         MAX_LEN   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_data_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_endofpacket,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] frame_len,
    output logic       busy,
    output logic       err_chk,
    output logic       err_fmt,
    output logic       err_abort,
    output logic       err_ovr
);

    localparam int         PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} stateT;

    stateT             state, nextState;
    logic [7:0]        acc;
    logic [7:0]        lenReg;
    logic [7:0]        frameLenReg;
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [7:0]        frameBuf [MAX_LEN];
    logic              setChk, setFmt, setAbort, setOvr;
    logic              lenOk, lastPayload, chkMatch, handshake, lastOut, takeByte;

    // One byte-wide step of the integrity accumulator.
    function automatic logic [7:0] foldByte(input logic [7:0] accIn, input logic [7:0] b);
`ifdef UART_DEFRAMER_CRC8_EN
        logic [7:0] c;
        c = accIn ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return accIn ^ b;
`endif
    endfunction

    // End-of-packet takes priority over a coincident byte in the framing states.
    assign takeByte    = rx_data_ready && !rx_endofpacket;
    assign lenOk       = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
    assign lastPayload = (8'(wrPtr) == lenReg - 8'd1);
    assign chkMatch    = (rx_data == acc);
    assign lastOut     = (8'(rdPtr) == frameLenReg - 8'd1);
    assign handshake   = (state == DRAIN) && out_ready;

    assign out_valid = (state == DRAIN);
    assign out_data  = (state == DRAIN) ? frameBuf[rdPtr] : 8'h00;
    assign out_last  = (state == DRAIN) && lastOut;
    assign frame_len = frameLenReg;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and error-pulse requests.
    always_comb begin
        nextState = state;
        setChk    = 1'b0;
        setFmt    = 1'b0;
        setAbort  = 1'b0;
        setOvr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_data_ready && rx_data == SYNC_BYTE) nextState = LEN;
            end
            LEN: begin
                if (rx_endofpacket) begin
                    setAbort  = 1'b1;
                    nextState = IDLE;
                end else if (rx_data_ready) begin
                    if (lenOk) begin
                        nextState = PAYLOAD;
                    end else begin
                        setFmt    = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_endofpacket) begin
                    setAbort  = 1'b1;
                    nextState = IDLE;
                end else if (rx_data_ready && lastPayload) begin
                    nextState = CHK;
                end
            end
            CHK: begin
                if (rx_endofpacket) begin
                    setAbort  = 1'b1;
                    nextState = IDLE;
                end else if (rx_data_ready) begin
                    if (chkMatch) begin
                        nextState = DRAIN;
                    end else begin
                        setChk    = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (rx_data_ready) setOvr = 1'b1;
                if (handshake && lastOut) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath registers: accumulator, length, pointers, registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= 8'h00;
            lenReg      <= 8'h00;
            frameLenReg <= 8'h00;
            wrPtr       <= '0;
            rdPtr       <= '0;
            err_chk     <= 1'b0;
            err_fmt     <= 1'b0;
            err_abort   <= 1'b0;
            err_ovr     <= 1'b0;
        end else begin
            err_chk   <= setChk;
            err_fmt   <= setFmt;
            err_abort <= setAbort;
            err_ovr   <= setOvr;
            unique case (state)
                IDLE: begin
                    if (rx_data_ready && rx_data == SYNC_BYTE) acc <= 8'h00;
                end
                LEN: begin
                    if (takeByte && lenOk) begin
                        lenReg <= rx_data;
                        acc    <= foldByte(8'h00, rx_data);
                        wrPtr  <= '0;
                    end
                end
                PAYLOAD: begin
                    if (takeByte) begin
                        acc   <= foldByte(acc, rx_data);
                        wrPtr <= wrPtr + 1'b1;
                    end
                end
                CHK: begin
                    if (takeByte && chkMatch) begin
                        frameLenReg <= lenReg;
                        rdPtr       <= '0;
                    end
                end
                DRAIN: begin
                    if (handshake) rdPtr <= rdPtr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset; contents are only read while draining.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && takeByte) frameBuf[wrPtr] <= rx_data;
    end

endmodule

// File: tb/tb_uart_frame_deframer.sv
// Directed self-checking bench for uart_frame_deframer; expected checksums follow UART_DEFRAMER_CRC8_EN.
`timescale 1ns/1ps

module tb_uart_frame_deframer;

`ifdef UART_DEFRAMER_CRC8_EN
    localparam logic [7:0] CHK_F1 = 8'hEE;
    localparam logic [7:0] CHK_F2 = 8'h15;
    localparam logic [7:0] BAD_F2 = 8'h01;
`else
    localparam logic [7:0] CHK_F1 = 8'h03;
    localparam logic [7:0] CHK_F2 = 8'h01;
    localparam logic [7:0] BAD_F2 = 8'h15;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_data_ready;
    logic [7:0] rx_data;
    logic       rx_endofpacket;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic [7:0] frame_len;
    logic       busy;
    logic       err_chk, err_fmt, err_abort, err_ovr;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;
    int chkPulses, fmtPulses, abortPulses, ovrPulses, validCycles;
    logic [7:0] logData [$];
    logic       logLast [$];
    int         logCycle [$];

    uart_frame_deframer #(.SYNC_BYTE(8'hAA), .MAX_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data_ready(rx_data_ready), .rx_data(rx_data), .rx_endofpacket(rx_endofpacket),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .frame_len(frame_len), .busy(busy),
        .err_chk(err_chk), .err_fmt(err_fmt), .err_abort(err_abort), .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge: valid&ready here is a handshake at the next rising edge.
    always @(negedge clk) begin
        cycleCount++;
        if (rst_n) begin
            if (err_chk)   chkPulses++;
            if (err_fmt)   fmtPulses++;
            if (err_abort) abortPulses++;
            if (err_ovr)   ovrPulses++;
            if (out_valid) validCycles++;
            if (out_valid && out_ready) begin
                logData.push_back(out_data);
                logLast.push_back(out_last);
                logCycle.push_back(cycleCount);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drives one byte for exactly one cycle; call 1 ns after a rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic pulseEop();
        rx_endofpacket = 1'b1;
        @(posedge clk); #1;
        rx_endofpacket = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitIdle(input int maxCycles, input string name);
        int n = 0;
        while (busy && n < maxCycles) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s: timed out, busy=%b required 0", name, busy);
        end
    endtask

    task automatic clearLog();
        logData.delete();
        logLast.delete();
        logCycle.delete();
        chkPulses = 0; fmtPulses = 0; abortPulses = 0; ovrPulses = 0; validCycles = 0;
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, out_data, out_last, frame_len, busy} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: valid=%b data=%h last=%b len=%h busy=%b required all 0",
                     out_valid, out_data, out_last, frame_len, busy);
        end
        checks++;
        if ({err_chk, err_fmt, err_abort, err_ovr} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_errors: got %b required 0000", {err_chk, err_fmt, err_abort, err_ovr});
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        clearLog();
        out_ready = 1'b1;
        applyStimulus(8'h55);
        applyStimulus(8'hAA);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(CHK_F1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            failures++;
            $display("[TB] FAIL basic_latency: valid=%b data=%h required 1/11", out_valid, out_data);
        end
        checks++;
        if (frame_len !== 8'd3) begin
            failures++;
            $display("[TB] FAIL basic_frame_len: got %0d required 3", frame_len);
        end
        waitIdle(10, "basic_drain");
        checks++;
        if (logData.size() !== 3) begin
            failures++;
            $display("[TB] FAIL basic_count: got %0d bytes required 3", logData.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (logData[i] !== exp[i] || logLast[i] !== (i == 2)) begin
                    failures++;
                    $display("[TB] FAIL basic_byte%0d: data=%h last=%b required %h/%b",
                             i, logData[i], logLast[i], exp[i], (i == 2));
                end
            end
            checks++;
            if (logCycle[2] - logCycle[0] !== 2) begin
                failures++;
                $display("[TB] FAIL basic_back_to_back: span %0d cycles required 2", logCycle[2] - logCycle[0]);
            end
        end
        checks++;
        if (chkPulses + fmtPulses + abortPulses + ovrPulses !== 0) begin
            failures++;
            $display("[TB] FAIL basic_no_errors: got %0d pulses required 0",
                     chkPulses + fmtPulses + abortPulses + ovrPulses);
        end
    endtask

    task automatic test_chk_error();
        clearLog();
        out_ready = 1'b1;
        applyStimulus(8'hAA);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h04);
        checks++;
        if (err_chk !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL chk_pulse: err_chk=%b busy=%b required 1/0", err_chk, busy);
        end
        idleCycles(1);
        checks++;
        if (err_chk !== 1'b0) begin
            failures++;
            $display("[TB] FAIL chk_single_cycle: err_chk=%b required 0", err_chk);
        end
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(CHK_F2);
        waitIdle(5, "chk_recover_drain");
        checks++;
        if (logData.size() !== 1 || validCycles !== 1) begin
            failures++;
            $display("[TB] FAIL chk_recover_count: bytes=%0d valid_cycles=%0d required 1/1",
                     logData.size(), validCycles);
        end else begin
            checks++;
            if (logData[0] !== 8'h00 || logLast[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL chk_recover_byte: data=%h last=%b required 00/1", logData[0], logLast[0]);
            end
        end
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(BAD_F2);
        idleCycles(2);
        checks++;
        if (chkPulses !== 2 || logData.size() !== 1) begin
            failures++;
            $display("[TB] FAIL chk_second_mismatch: pulses=%0d bytes=%0d required 2/1", chkPulses, logData.size());
        end
    endtask

    task automatic test_fmt_error();
        clearLog();
        applyStimulus(8'hAA);
        applyStimulus(8'h00);
        checks++;
        if (err_fmt !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fmt_zero: err_fmt=%b busy=%b required 1/0", err_fmt, busy);
        end
        applyStimulus(8'hAA);
        applyStimulus(8'h11);
        checks++;
        if (err_fmt !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fmt_too_long: err_fmt=%b busy=%b required 1/0", err_fmt, busy);
        end
        idleCycles(2);
        checks++;
        if (fmtPulses !== 2) begin
            failures++;
            $display("[TB] FAIL fmt_pulse_count: got %0d required 2", fmtPulses);
        end
    endtask

`ifndef UART_DEFRAMER_CRC8_EN
    task automatic test_max_len();
        clearLog();
        out_ready = 1'b1;
        applyStimulus(8'hAA);
        applyStimulus(8'h10);
        for (int i = 0; i < 16; i++) applyStimulus(8'(i));
        applyStimulus(8'h10);
        checks++;
        if (frame_len !== 8'd16) begin
            failures++;
            $display("[TB] FAIL maxlen_frame_len: got %0d required 16", frame_len);
        end
        waitIdle(25, "maxlen_drain");
        checks++;
        if (logData.size() !== 16) begin
            failures++;
            $display("[TB] FAIL maxlen_count: got %0d required 16", logData.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (logData[i] !== 8'(i) || logLast[i] !== (i == 15)) begin
                    failures++;
                    $display("[TB] FAIL maxlen_byte%0d: data=%h last=%b required %h/%b",
                             i, logData[i], logLast[i], 8'(i), (i == 15));
                end
            end
        end
    endtask
`endif

    task automatic test_abort();
        clearLog();
        applyStimulus(8'hAA);
        applyStimulus(8'h02);
        applyStimulus(8'h7E);
        pulseEop();
        checks++;
        if (err_abort !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_payload: err_abort=%b busy=%b required 1/0", err_abort, busy);
        end
        applyStimulus(8'hAA);
        applyStimulus(8'h02);
        rx_data        = 8'h7E;
        rx_data_ready  = 1'b1;
        rx_endofpacket = 1'b1;
        @(posedge clk); #1;
        rx_data_ready  = 1'b0;
        rx_endofpacket = 1'b0;
        checks++;
        if (err_abort !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_coincident: err_abort=%b busy=%b required 1/0", err_abort, busy);
        end
        pulseEop();
        idleCycles(1);
        checks++;
        if (abortPulses !== 2) begin
            failures++;
            $display("[TB] FAIL abort_idle_ignored: pulses=%0d required 2", abortPulses);
        end
    endtask

    task automatic test_overrun();
        clearLog();
        out_ready = 1'b0;
        applyStimulus(8'hAA);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(CHK_F1);
        applyStimulus(8'h5A);
        checks++;
        if (err_ovr !== 1'b1 || busy !== 1'b1 || out_data !== 8'h11) begin
            failures++;
            $display("[TB] FAIL ovr_pulse: err_ovr=%b busy=%b data=%h required 1/1/11", err_ovr, busy, out_data);
        end
        applyStimulus(8'hAA);
        pulseEop();
        idleCycles(3);
        checks++;
        if (err_ovr !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovr_hold: err_ovr=%b valid=%b data=%h last=%b required 0/1/11/0",
                     err_ovr, out_valid, out_data, out_last);
        end
        checks++;
        if (ovrPulses !== 2 || abortPulses !== 0) begin
            failures++;
            $display("[TB] FAIL ovr_counts: ovr=%0d abort=%0d required 2/0", ovrPulses, abortPulses);
        end
        out_ready = 1'b1;
        waitIdle(10, "ovr_drain");
        checks++;
        if (logData.size() !== 3) begin
            failures++;
            $display("[TB] FAIL ovr_drain_count: got %0d required 3", logData.size());
        end else begin
            checks++;
            if (logData[0] !== 8'h11 || logData[2] !== 8'h33 || logLast[2] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ovr_drain_bytes: first=%h last=%h last_flag=%b required 11/33/1",
                         logData[0], logData[2], logLast[2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clearLog();
        out_ready = 1'b1;
        applyStimulus(8'hAA);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL rst_payload: valid=%b last=%b busy=%b required 000", out_valid, out_last, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        idleCycles(1);
        applyStimulus(8'hAA);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(CHK_F1);
        waitIdle(10, "rst_payload_recover");
        checks++;
        if (logData.size() !== 3 || logData[logData.size()-1] !== 8'h33) begin
            failures++;
            $display("[TB] FAIL rst_payload_recover: bytes=%0d required 3 ending in 33", logData.size());
        end
        clearLog();
        out_ready = 1'b0;
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(CHK_F2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_last, frame_len, busy} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL rst_drain: valid=%b data=%h last=%b len=%h busy=%b required all 0",
                     out_valid, out_data, out_last, frame_len, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        idleCycles(1);
        out_ready = 1'b1;
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(CHK_F2);
        waitIdle(5, "rst_drain_recover");
        checks++;
        if (logData.size() !== 1 || logData[0] !== 8'h00 || logLast[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_drain_recover: bytes=%0d required a single 00 with last", logData.size());
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        rx_data_ready  = 1'b0;
        rx_data        = 8'h00;
        rx_endofpacket = 1'b0;
        out_ready      = 1'b0;
        clearLog();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        idleCycles(1);
        test_basic_frame();
        test_chk_error();
        test_fmt_error();
`ifndef UART_DEFRAMER_CRC8_EN
        test_max_len();
`endif
        test_abort();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
